// File: rtl/spi_config_master.sv
// SPI mode-0 master: sends FrameWords words MSB-first under one cs-low window, stalling with cs low between words.
// wordReady is high only in IDLE/STALL; abort ends the frame on the next cycle; every output is registered.
module spi_config_master #(
  parameter int WordWidth  = 16,
  parameter int FrameWords = 7,
  parameter int ClkDiv     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WordWidth-1:0] wordData,
  input  logic                 wordValid,
  output logic                 wordReady,
  input  logic                 abort,
  output logic                 spiClk,
  output logic                 mosi,
  output logic                 cs,
  output logic                 busy,
  output logic                 frameDone
);

  localparam int DivW  = $clog2(ClkDiv);
  localparam int BitW  = $clog2(WordWidth);
  localparam int WordW = (FrameWords > 1) ? $clog2(FrameWords) : 1;

  localparam logic [DivW-1:0]  DivLast  = DivW'(ClkDiv - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WordWidth - 1);
  localparam logic [WordW-1:0] WordLast = WordW'(FrameWords - 1);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, STALL, TRAIL, GAP} stateT;

  stateT                state;
  logic [DivW-1:0]      divCnt;
  logic [BitW-1:0]      bitCnt;
  logic [WordW-1:0]     wordCnt;
  // Bits still to send below the one currently on mosi.
  logic [WordWidth-2:0] shiftReg;

  logic handshake;
  logic phaseEnd;

  assign handshake = wordValid && wordReady;
  assign phaseEnd  = (divCnt == DivLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      divCnt    <= '0;
      bitCnt    <= '0;
      wordCnt   <= '0;
      shiftReg  <= '0;
      cs        <= 1'b1;
      spiClk    <= 1'b0;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      frameDone <= 1'b0;
      wordReady <= 1'b1;
    end else begin
      frameDone <= 1'b0;
      // Abort beats a coincident STALL handshake, so that word is simply dropped.
      if (abort && state != IDLE) begin
        state     <= GAP;
        divCnt    <= '0;
        cs        <= 1'b1;
        spiClk    <= 1'b0;
        mosi      <= 1'b0;
        wordReady <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (handshake) begin
              state     <= LEAD;
              divCnt    <= '0;
              bitCnt    <= '0;
              wordCnt   <= '0;
              shiftReg  <= wordData[WordWidth-2:0];
              mosi      <= wordData[WordWidth-1];
              cs        <= 1'b0;
              busy      <= 1'b1;
              wordReady <= 1'b0;
            end
          end
          LEAD, LOW: begin
            divCnt <= phaseEnd ? '0 : divCnt + DivW'(1);
            if (phaseEnd) begin
              state  <= HIGH;
              spiClk <= 1'b1;
            end
          end
          HIGH: begin
            divCnt <= phaseEnd ? '0 : divCnt + DivW'(1);
            if (phaseEnd) begin
              spiClk <= 1'b0;
              if (bitCnt != BitLast) begin
                // Shift on the falling edge so mosi holds through the whole HIGH phase.
                state    <= LOW;
                mosi     <= shiftReg[WordWidth-2];
                shiftReg <= {shiftReg[WordWidth-3:0], 1'b0};
                bitCnt   <= bitCnt + BitW'(1);
              end else if (wordCnt != WordLast) begin
                state     <= STALL;
                wordReady <= 1'b1;
              end else begin
                state <= TRAIL;
              end
            end
          end
          STALL: begin
            if (handshake) begin
              state     <= LOW;
              divCnt    <= '0;
              bitCnt    <= '0;
              wordCnt   <= wordCnt + WordW'(1);
              shiftReg  <= wordData[WordWidth-2:0];
              mosi      <= wordData[WordWidth-1];
              wordReady <= 1'b0;
            end
          end
          TRAIL: begin
            divCnt <= phaseEnd ? '0 : divCnt + DivW'(1);
            if (phaseEnd) begin
              state     <= GAP;
              cs        <= 1'b1;
              mosi      <= 1'b0;
              frameDone <= 1'b1;
            end
          end
          GAP: begin
            divCnt <= phaseEnd ? '0 : divCnt + DivW'(1);
            if (phaseEnd) begin
              state     <= IDLE;
              busy      <= 1'b0;
              wordReady <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_config_master.sv
// Bench: SPI slave monitor checks received words and frame outcomes against queues filled by the stimulus.
module tb_spi_config_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] dataA = '0, dataB = '0;
  logic validA = 1'b0, validB = 1'b0, abortA = 1'b0, abortB = 1'b0;
  logic readyA, sclkA, mosiA, csA, busyA, doneA;
  logic readyB, sclkB, mosiB, csB, busyB, doneB;

  spi_config_master #(.WordWidth(16), .FrameWords(1), .ClkDiv(2)) dutA (
    .clk(clk), .reset(reset), .wordData(dataA), .wordValid(validA), .wordReady(readyA),
    .abort(abortA), .spiClk(sclkA), .mosi(mosiA), .cs(csA), .busy(busyA), .frameDone(doneA)
  );

  spi_config_master #(.WordWidth(16), .FrameWords(7), .ClkDiv(4)) dutB (
    .clk(clk), .reset(reset), .wordData(dataB), .wordValid(validB), .wordReady(readyB),
    .abort(abortB), .spiClk(sclkB), .mosi(mosiB), .cs(csB), .busy(busyB), .frameDone(doneB)
  );

  typedef logic [15:0] frameT [7];

  int checks = 0, errors = 0;
  logic [15:0] expWords[$];
  int          expFrameWords[$];
  bit          expFrameDone[$];
  bit          b2b = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Slave-side monitor for dutB: samples on the falling clk edge, away from DUT updates.
  logic        prevCs = 1'b1, prevSclk = 1'b0, prevMosi = 1'b0;
  logic [15:0] rxSr = '0;
  int rxBits = 0, rxWords = 0, runLen = 0, gapLen = 1000, stallRun = 0;

  always @(negedge clk) begin
    if (sclkB && !prevSclk) begin
      check("sclkRiseCsLow", 32'(csB), 0);
      if (!csB) begin
        rxSr = {rxSr[14:0], mosiB};
        rxBits++;
        if (rxBits == 16) begin
          rxBits = 0;
          rxWords++;
          if (expWords.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wordUnexpected actual=%0h required=none", rxSr);
          end else begin
            check("word", 32'(rxSr), 32'(expWords.pop_front()));
          end
        end
      end
    end

    if (csB) runLen = 0;
    else if (sclkB != prevSclk) begin
      if (!prevCs) check("phaseLenAtLeast4", 32'(runLen >= 4), 1);
      runLen = 1;
    end else runLen++;

    if (mosiB != prevMosi) check("mosiChangeSclkLow", 32'(sclkB), 0);

    if (csB && !prevCs) begin
      if (expFrameWords.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frameUnexpected actual=%0d required=none", rxWords);
      end else begin
        check("frameWords", rxWords, expFrameWords.pop_front());
        check("frameDone", 32'(doneB), 32'(expFrameDone.pop_front()));
      end
      rxWords = 0;
      rxBits  = 0;
      gapLen  = 1;
    end else if (csB) begin
      gapLen++;
    end else if (prevCs) begin
      check("csGapAtLeast4", 32'(gapLen >= 4), 1);
    end

    if (doneB) check("frameDoneWithCsRise", 32'(csB && !prevCs), 1);

    if (busyB && readyB) stallRun++;
    else begin
      if (stallRun > 0 && b2b) check("stallCycles", stallRun, 1);
      stallRun = 0;
    end

    prevCs   = csB;
    prevSclk = sclkB;
    prevMosi = mosiB;
  end

  task automatic sendB(input logic [15:0] w);
    int n = 0;
    validB = 1'b1;
    dataB  = w;
    while (!readyB && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!readyB) begin
      checks++;
      errors++;
      $display("FAIL handshakeTimeout actual=notReady required=ready");
    end
    @(posedge clk);
    @(negedge clk);
    validB = 1'b0;
  endtask

  task automatic waitIdleB();
    int n = 0;
    while (busyB && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (busyB) begin
      checks++;
      errors++;
      $display("FAIL idleTimeout actual=busy required=idle");
    end
  endtask

  task automatic sendFrame(input frameT w, input int gapMax);
    expFrameWords.push_back(7);
    expFrameDone.push_back(1'b1);
    for (int k = 0; k < 7; k++) begin
      expWords.push_back(w[k]);
      repeat ($urandom_range(0, gapMax)) @(negedge clk);
      sendB(w[k]);
    end
    waitIdleB();
  endtask

  task automatic randomFrame(output frameT w);
    for (int k = 0; k < 7; k++) w[k] = 16'($urandom);
  endtask

  task automatic runSingleWord();
    int lowCnt = 0, rises = 0;
    logic prevS = 1'b0;
    logic [15:0] sr = '0;
    validA = 1'b1;
    dataA  = 16'hA5C3;
    @(posedge clk);
    @(negedge clk);
    validA = 1'b0;
    check("aCsFallCycle1", 32'(csA), 0);
    while (!csA && lowCnt < 1000) begin
      lowCnt++;
      if (sclkA && !prevS) begin
        rises++;
        sr = {sr[14:0], mosiA};
      end
      prevS = sclkA;
      @(negedge clk);
    end
    check("aCsLowCycles", lowCnt, 66);
    check("aRisingEdges", rises, 16);
    check("aData", 32'(sr), 32'hA5C3);
    check("aDoneAtCsRise", 32'(doneA), 1);
    @(negedge clk);
    check("aDonePulseWidth", 32'(doneA), 0);
    check("aReadyGap1", 32'(readyA), 0);
    @(negedge clk);
    check("aReadyGap2", 32'(readyA), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frameT fr;
    logic [15:0] w0, w1;
    int n, rises;
    logic prevS;
    bit holdOk;

    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstCsB", 32'(csB), 1);
    check("rstSclkB", 32'(sclkB), 0);
    check("rstMosiB", 32'(mosiB), 0);
    check("rstBusyB", 32'(busyB), 0);
    check("rstDoneB", 32'(doneB), 0);
    check("rstReadyB", 32'(readyB), 1);
    check("rstCsA", 32'(csA), 1);
    check("rstSclkA", 32'(sclkA), 0);
    check("rstMosiA", 32'(mosiA), 0);
    check("rstBusyA", 32'(busyA), 0);
    check("rstDoneA", 32'(doneA), 0);
    check("rstReadyA", 32'(readyA), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    runSingleWord();

    // Back-to-back 0x0001..0x0007.
    b2b = 1'b1;
    for (int k = 0; k < 7; k++) fr[k] = 16'(k + 1);
    sendFrame(fr, 0);
    b2b = 1'b0;

    // Second word held back 20 cycles: cs and spiClk must stay low throughout.
    randomFrame(fr);
    expFrameWords.push_back(7);
    expFrameDone.push_back(1'b1);
    expWords.push_back(fr[0]);
    sendB(fr[0]);
    n = 0;
    while (!readyB && n < 1000) begin
      @(negedge clk);
      n++;
    end
    holdOk = 1'b1;
    repeat (20) begin
      if (csB || sclkB || !readyB) holdOk = 1'b0;
      @(negedge clk);
    end
    check("stallHold", 32'(holdOk), 1);
    for (int k = 1; k < 7; k++) begin
      expWords.push_back(fr[k]);
      sendB(fr[k]);
    end
    waitIdleB();

    // Abort in the sixth HIGH phase of word 1; only word 0 completes.
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    expFrameWords.push_back(1);
    expFrameDone.push_back(1'b0);
    expWords.push_back(w0);
    sendB(w0);
    sendB(w1);
    rises = 0;
    n = 0;
    prevS = sclkB;
    while (rises < 6 && n < 1000) begin
      @(negedge clk);
      n++;
      if (sclkB && !prevS) rises++;
      prevS = sclkB;
    end
    check("abortReachedBit5", rises, 6);
    abortB = 1'b1;
    @(posedge clk);
    #1;
    check("abortCs", 32'(csB), 1);
    check("abortSclk", 32'(sclkB), 0);
    check("abortMosi", 32'(mosiB), 0);
    check("abortNoDone", 32'(doneB), 0);
    @(negedge clk);
    abortB = 1'b0;
    waitIdleB();
    randomFrame(fr);
    fr[0] = 16'h1234;
    sendFrame(fr, 3);

    // Asynchronous reset mid-frame.
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    expFrameWords.push_back(1);
    expFrameDone.push_back(1'b0);
    expWords.push_back(w0);
    sendB(w0);
    sendB(w1);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("asyncRstCs", 32'(csB), 1);
    check("asyncRstSclk", 32'(sclkB), 0);
    check("asyncRstBusy", 32'(busyB), 0);
    check("asyncRstReady", 32'(readyB), 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    randomFrame(fr);
    sendFrame(fr, 2);

    // Random data with random valid gaps.
    for (int f = 0; f < 3; f++) begin
      randomFrame(fr);
      sendFrame(fr, 10);
    end

    repeat (10) @(negedge clk);
    check("wordsLeft", expWords.size(), 0);
    check("framesLeft", expFrameWords.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
